// File: rtl/matrix_pkg.sv
// Shared state encoding, row count and color-select codes for the LED matrix scanner.
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } state_e;

  localparam int NUM_ROWS = 8;

  localparam logic [1:0] SEL_GREEN = 2'b01;
  localparam logic [1:0] SEL_RED   = 2'b10;
  localparam logic [1:0] SEL_BOTH  = 2'b11;

  function automatic logic [NUM_ROWS-1:0] row_onehot(input logic [$clog2(NUM_ROWS)-1:0] r);
    return NUM_ROWS'(1) << r;
  endfunction

endpackage

// File: rtl/matrix_timebase.sv
// Row-period timer: a down-counter that flags the last blank cycle and the last drive cycle.
module matrix_timebase #(
  parameter int SCAN_DIV  = 4096,
  parameter int BLANK_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic blank_done_o,
  output logic drive_done_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] TOP       = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(SCAN_DIV - BLANK_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Held at TOP while idle so the first period after start is full length.
  always_comb begin
    cnt_d = cnt_q - CNT_W'(1);
    if (clear_i || cnt_q == '0) cnt_d = TOP;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= TOP;
    else         cnt_q <= cnt_d;
  end

  assign blank_done_o = !clear_i && (cnt_q == BLANK_END);
  assign drive_done_o = !clear_i && (cnt_q == '0);

endmodule

// File: rtl/matrix_scan_ctrl.sv
// Scan sequencer for the 8x8 bicolor matrix: row blanking/drive, frame counting, scroll stepping.
//   state | meaning
//   IDLE  | all pins low, waiting for start
//   BLANK | row dark, ROM addressed with (row, offset)
//   DRIVE | one row lit with the latched column byte
module matrix_scan_ctrl
  import matrix_pkg::*;
#(
  parameter int SCAN_DIV      = 4096,
  parameter int BLANK_CYC     = 16,
  parameter int SCROLL_FRAMES = 64,
  parameter int MSG_LEN       = 72
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       pause_i,
  input  logic [1:0] sel_i,
  output logic [2:0] rd_row_o,
  output logic [6:0] rd_offset_o,
  input  logic [7:0] rd_data_i,
  output logic [7:0] row_o,
  output logic [7:0] column_green_o,
  output logic [7:0] column_red_o,
  output logic       busy_o,
  output logic       frame_tick_o,
  output logic       wrap_o
);

  localparam int ROW_W   = $clog2(NUM_ROWS);
  localparam int FRAME_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
  localparam logic [ROW_W-1:0]   LAST_ROW    = ROW_W'(NUM_ROWS - 1);
  localparam logic [FRAME_W-1:0] LAST_FRAME  = FRAME_W'(SCROLL_FRAMES - 1);
  localparam logic [6:0]         LAST_OFFSET = 7'(MSG_LEN - 1);

  state_e             state_q;
  logic [ROW_W-1:0]   row_idx_q;
  logic [6:0]         offset_q, offset_d;
  logic [FRAME_W-1:0] frame_q;
  logic [1:0]         sel_q;
  logic [7:0]         col_q;
  logic [7:0]         row_q, green_q, red_q;
  logic               busy_q, tick_q, wrap_q;
  logic               tb_clear, blank_done, drive_done, offset_last, frame_last;

  assign tb_clear = (state_q == IDLE);

  matrix_timebase #(
    .SCAN_DIV (SCAN_DIV),
    .BLANK_CYC(BLANK_CYC)
  ) u_timebase (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (tb_clear),
    .blank_done_o(blank_done),
    .drive_done_o(drive_done)
  );

  assign offset_last = (offset_q == LAST_OFFSET);
  assign frame_last  = (frame_q == LAST_FRAME);
  assign offset_d    = offset_last ? 7'd0 : offset_q + 7'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      offset_q  <= '0;
      frame_q   <= '0;
      sel_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      green_q   <= '0;
      red_q     <= '0;
      busy_q    <= 1'b0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      if (stop_i) begin
        state_q   <= IDLE;
        busy_q    <= 1'b0;
        row_idx_q <= '0;
        offset_q  <= '0;
        frame_q   <= '0;
        row_q     <= '0;
        green_q   <= '0;
        red_q     <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              state_q   <= BLANK;
              busy_q    <= 1'b1;
              row_idx_q <= '0;
              offset_q  <= '0;
              frame_q   <= '0;
              sel_q     <= sel_i;
            end
          end
          BLANK: begin
            if (blank_done) begin
              // ROM byte is valid by now; pins take it directly so drive starts next cycle.
              state_q <= DRIVE;
              col_q   <= rd_data_i;
              row_q   <= row_onehot(row_idx_q);
              green_q <= ((sel_q & SEL_GREEN) != 2'b00) ? rd_data_i : 8'h00;
              red_q   <= ((sel_q & SEL_RED) != 2'b00) ? rd_data_i : 8'h00;
            end
          end
          DRIVE: begin
            if (drive_done) begin
              state_q <= BLANK;
              row_q   <= '0;
              green_q <= '0;
              red_q   <= '0;
              if (row_idx_q == LAST_ROW) begin
                row_idx_q <= '0;
                tick_q    <= 1'b1;
                sel_q     <= sel_i;
                if (frame_last) begin
                  frame_q <= '0;
                  if (!pause_i) begin
                    offset_q <= offset_d;
                    wrap_q   <= offset_last;
                  end
                end else begin
                  frame_q <= frame_q + FRAME_W'(1);
                end
              end else begin
                row_idx_q <= row_idx_q + ROW_W'(1);
              end
            end else begin
              green_q <= ((sel_q & SEL_GREEN) != 2'b00) ? col_q : 8'h00;
              red_q   <= ((sel_q & SEL_RED) != 2'b00) ? col_q : 8'h00;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign rd_row_o       = row_idx_q;
  assign rd_offset_o    = offset_q;
  assign row_o          = row_q;
  assign column_green_o = green_q;
  assign column_red_o   = red_q;
  assign busy_o         = busy_q;
  assign frame_tick_o   = tick_q;
  assign wrap_o         = wrap_q;

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: cycle-count model of the scan schedule plus hand-pinned values.
module tb_matrix_scan_ctrl;

  localparam int SD  = 16;
  localparam int BC  = 4;
  localparam int SF  = 2;
  localparam int ML  = 5;
  localparam int FRAME_CYC = 8 * SD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause;
  logic [1:0] sel;
  logic [2:0] rd_row;
  logic [6:0] rd_offset;
  logic [7:0] rd_data;
  logic [7:0] row, column_green, column_red;
  logic       busy, frame_tick, wrap;

  int n_checks = 0;
  int n_err    = 0;
  int n_tick   = 0;
  int n_wrap   = 0;
  bit cmp_en   = 1'b0;

  // Model state: cycles since the first BLANK cycle, offset, frame count, latched sel.
  bit         m_act;
  int         m_k, m_off, m_fc;
  logic [1:0] m_sel;
  bit         m_tick, m_wrap;

  always #5 clk = ~clk;

  matrix_scan_ctrl #(
    .SCAN_DIV(SD), .BLANK_CYC(BC), .SCROLL_FRAMES(SF), .MSG_LEN(ML)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .pause_i(pause),
    .sel_i(sel), .rd_row_o(rd_row), .rd_offset_o(rd_offset), .rd_data_i(rd_data),
    .row_o(row), .column_green_o(column_green), .column_red_o(column_red),
    .busy_o(busy), .frame_tick_o(frame_tick), .wrap_o(wrap)
  );

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= 8'h00;
    else        rd_data <= {rd_offset[3:0], 1'b0, rd_row};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act = 0; m_k = 0; m_off = 0; m_fc = 0; m_sel = 2'b00; m_tick = 0; m_wrap = 0;
    end else begin
      m_tick = 0;
      m_wrap = 0;
      if (stop) m_act = 0;
      else if (!m_act) begin
        if (start) begin
          m_act = 1; m_k = 0; m_off = 0; m_fc = 0; m_sel = sel;
        end
      end else begin
        m_k++;
        if (m_k % FRAME_CYC == 0) begin
          m_tick = 1;
          m_sel  = sel;
          if (m_fc == SF - 1) begin
            m_fc = 0;
            if (!pause) begin
              if (m_off == ML - 1) begin m_off = 0; m_wrap = 1; end
              else m_off++;
            end
          end else m_fc++;
        end
      end
    end
  end

  always @(negedge clk) begin
    int ph, r;
    logic [7:0] b, e_row, e_g, e_r;
    if (cmp_en) begin
      ph = m_k % SD;
      r  = (m_k / SD) % 8;
      b  = {m_off[3:0], 1'b0, r[2:0]};
      e_row = (m_act && ph >= BC) ? (8'h01 << r) : 8'h00;
      e_g   = (m_act && ph >= BC && m_sel[0]) ? b : 8'h00;
      e_r   = (m_act && ph >= BC && m_sel[1]) ? b : 8'h00;
      chk("busy", 32'(busy), 32'(m_act));
      chk("rd_row", 32'(rd_row), m_act ? 32'(r) : 32'd0);
      chk("rd_offset", 32'(rd_offset), m_act ? 32'(m_off) : 32'd0);
      chk("row", 32'(row), 32'(e_row));
      chk("column_green", 32'(column_green), 32'(e_g));
      chk("column_red", 32'(column_red), 32'(e_r));
      chk("frame_tick", 32'(frame_tick), 32'(m_tick));
      chk("wrap", 32'(wrap), 32'(m_wrap));
      n_tick += int'(frame_tick);
      n_wrap += int'(wrap);
    end
  end

  task automatic wait_k(input int target);
    int budget = 4000;
    @(negedge clk);
    while (!(m_act && m_k == target) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) begin
      n_err++;
      $display("FAIL wait_k timeout waiting for k=%0d (k=%0d act=%0d)", target, m_k, m_act);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; sel = 2'b01;
    cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_row", 32'(row), 32'd0);
    chk("rst_rd_row", 32'(rd_row), 32'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Start: BLANK from the next cycle, row 0 lit after four blank cycles.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_tick = 0; n_wrap = 0;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_rd_row", 32'(rd_row), 32'd0);
    chk("start_rd_offset", 32'(rd_offset), 32'd0);
    chk("start_row_blank", 32'(row), 32'd0);
    repeat (3) @(negedge clk);
    chk("last_blank_row", 32'(row), 32'd0);
    @(negedge clk);
    chk("drive0_row", 32'(row), 32'h01);
    chk("drive0_green", 32'(column_green), 32'h00);
    chk("drive0_red", 32'(column_red), 32'h00);

    wait_k(20);
    chk("drive1_row", 32'(row), 32'h02);
    chk("drive1_green", 32'(column_green), 32'h01);
    wait_k(128);
    chk("tick_at_frame", 32'(frame_tick), 32'd1);
    chk("tick_rd_row", 32'(rd_row), 32'd0);
    wait_k(129);
    chk("tick_one_cycle", 32'(frame_tick), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_k(261);
    chk("step1_offset", 32'(rd_offset), 32'd1);
    chk("step1_green", 32'(column_green), 32'h10);
    wait_k(1290);
    #1;
    chk("ticks_to_wrap", 32'(n_tick), 32'd10);
    chk("wraps_once", 32'(n_wrap), 32'd1);
    chk("offset_wrapped", 32'(rd_offset), 32'd0);

    // Pause across three frame boundaries.
    pause = 1'b1;
    n_tick = 0;
    wait_k(1700);
    #1;
    chk("pause_offset", 32'(rd_offset), 32'd0);
    chk("pause_ticks", 32'(n_tick), 32'd3);
    pause = 1'b0;
    wait_k(1800);
    chk("resume_offset", 32'(rd_offset), 32'd1);

    // Color select is only taken at a frame boundary.
    sel = 2'b10;
    wait_k(1830);
    chk("midframe_green", 32'(column_green), 32'h12);
    chk("midframe_red", 32'(column_red), 32'h00);
    wait_k(1925);
    chk("newframe_red", 32'(column_red), 32'h10);
    chk("newframe_green", 32'(column_green), 32'h00);
    wait_k(1930);
    sel = 2'b00;
    wait_k(2104);
    chk("dark_row", 32'(row), 32'h08);
    chk("dark_green", 32'(column_green), 32'h00);
    chk("dark_red", 32'(column_red), 32'h00);
    chk("dark_offset", 32'(rd_offset), 32'd2);

    // Stop in DRIVE of row 3, then restart.
    wait_k(2106);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_busy", 32'(busy), 32'd0);
    chk("stop_row", 32'(row), 32'd0);
    chk("stop_rd_row", 32'(rd_row), 32'd0);
    chk("stop_rd_offset", 32'(rd_offset), 32'd0);
    sel = 2'b11;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_offset", 32'(rd_offset), 32'd0);
    wait_k(21);
    chk("restart_row", 32'(row), 32'h02);
    chk("restart_green", 32'(column_green), 32'h01);
    chk("restart_red", 32'(column_red), 32'h01);

    // Stop and start together: stop wins.
    stop = 1'b1; start = 1'b1;
    @(negedge clk);
    stop = 1'b0; start = 1'b0;
    chk("stop_wins_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("stays_idle", 32'(busy), 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;

    // Asynchronous reset mid-BLANK of row 2.
    wait_k(33);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_rd_row", 32'(rd_row), 32'd0);
    chk("arst_rd_offset", 32'(rd_offset), 32'd0);
    chk("arst_row", 32'(row), 32'd0);
    chk("arst_cols", 32'({column_green, column_red}), 32'd0);
    chk("arst_pulses", 32'({frame_tick, wrap}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
